// File: rtl/uart_tx_axis.sv
// AXI-Stream to UART transmitter: a small circular FIFO feeding a
// start/data/parity/stop serialiser with a glitch-free registered tx.
module uart_tx_axis #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 100,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                        aclk,
  input  logic                        arstn,
  input  logic [DATA_WIDTH-1:0]       s_data_tdata,
  input  logic                        s_data_tvalid,
  output logic                        s_data_tready,
  output logic                        tx,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned BIT_W = $clog2(DATA_WIDTH);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]      level_q;
  logic                  rst_hold_q;
  logic                  push, pop, load, cnt_end;
  logic [DATA_WIDTH-1:0] head;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic                  stop_q, stop_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_q, par_d;
  logic                  tx_q, tx_d;

  assign s_data_tready = (level_q != LVL_W'(FIFO_DEPTH)) && !rst_hold_q;
  assign push          = s_data_tvalid && s_data_tready;
  assign head          = mem_q[rd_ptr_q];
  assign cnt_end       = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      rst_hold_q <= 1'b1;
    end else begin
      rst_hold_q <= 1'b0;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      level_q <= level_q + LVL_W'(1);
      else if (pop && !push) level_q <= level_q - LVL_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (push) mem_q[wr_ptr_q] <= s_data_tdata;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    stop_d  = stop_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    load    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (level_q != '0) load = 1'b1;
      end
      S_START: begin
        if (cnt_end) begin
          state_d = S_DATA;
          cnt_d   = '0;
          bit_d   = '0;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end
      S_DATA: begin
        if (cnt_end) begin
          cnt_d = '0;
          if (bit_q == BIT_W'(DATA_WIDTH - 1)) begin
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
              stop_d  = 1'b0;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (cnt_end) begin
          state_d = S_STOP;
          cnt_d   = '0;
          tx_d    = 1'b1;
          stop_d  = 1'b0;
        end
      end
      S_STOP: begin
        if (cnt_end) begin
          cnt_d = '0;
          if (stop_q == 1'(STOP_BITS - 1)) begin
            if (level_q != '0) begin
              load = 1'b1;
            end else begin
              state_d = S_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Shared by IDLE and end-of-stop so back-to-back frames start with no gap.
    if (load) begin
      state_d = S_START;
      cnt_d   = '0;
      shreg_d = head;
      par_d   = (PARITY == 1) ? ~^head : ^head;
      tx_d    = 1'b0;
    end
  end

  assign pop = load;

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE) || (level_q != '0);
  assign fifo_level = level_q;

endmodule

// File: tb/tb_uart_tx_axis.sv
// Scoreboard bench for uart_tx_axis: four parameterisations share one clock/reset;
// stimulus queues expected frames, per-DUT line monitors decode tx and compare.
module tb_uart_tx_axis;
  localparam int CPB = 100;
  localparam int DW_T   [4] = '{8, 8, 8, 7};
  localparam int PAR_T  [4] = '{0, 2, 1, 0};
  localparam int STOP_T [4] = '{1, 1, 1, 2};

  typedef struct {
    int         id;
    logic [7:0] d;
    logic       par;
    logic       gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       arstn = 1'b0;
  logic [7:0] td [4];
  logic [3:0] tvalid = '0;
  wire  [3:0] tready, txw, busy;
  wire  [2:0] lvl [4];
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;
  exp_t       sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_axis #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(1)) dut0 (
    .aclk(clk), .arstn(arstn), .s_data_tdata(td[0]), .s_data_tvalid(tvalid[0]),
    .s_data_tready(tready[0]), .tx(txw[0]), .busy(busy[0]), .fifo_level(lvl[0]));
  uart_tx_axis #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY(2), .STOP_BITS(1)) dut1 (
    .aclk(clk), .arstn(arstn), .s_data_tdata(td[1]), .s_data_tvalid(tvalid[1]),
    .s_data_tready(tready[1]), .tx(txw[1]), .busy(busy[1]), .fifo_level(lvl[1]));
  uart_tx_axis #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY(1), .STOP_BITS(1)) dut2 (
    .aclk(clk), .arstn(arstn), .s_data_tdata(td[2]), .s_data_tvalid(tvalid[2]),
    .s_data_tready(tready[2]), .tx(txw[2]), .busy(busy[2]), .fifo_level(lvl[2]));
  uart_tx_axis #(.DATA_WIDTH(7), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .PARITY(0), .STOP_BITS(2)) dut3 (
    .aclk(clk), .arstn(arstn), .s_data_tdata(td[3][6:0]), .s_data_tvalid(tvalid[3]),
    .s_data_tready(tready[3]), .tx(txw[3]), .busy(busy[3]), .fifo_level(lvl[3]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Offers one word; returns at posedge+1 of the accepting edge with k = cyc.
  task automatic push(input int id, input logic [7:0] d, input logic par, input logic gap,
                      output int k);
    logic r;
    bit   ok = 1'b0;
    exp_t f;
    td[id]     = d;
    tvalid[id] = 1'b1;
    k = -1;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      r = tready[id];
      @(posedge clk);
      #1;
      if (r) begin ok = 1'b1; break; end
    end
    check($sformatf("push_accept dut%0d %02h", id, d), {31'd0, ok}, 32'd1);
    if (ok) begin
      k = cyc;
      f.id = id; f.d = d; f.par = par; f.gap = gap;
      sb.push_back(f);
    end
  endtask

  // Samples after edge k+L (busy still set) and k+L+1 (frame done).
  task automatic frame_end(input int id, input int k, input int len);
    while (cyc < k + len) @(negedge clk);
    check($sformatf("busy_last_cycle dut%0d", id), {31'd0, busy[id]}, 32'd1);
    @(negedge clk);
    check($sformatf("busy_after_frame dut%0d", id), {31'd0, busy[id]}, 32'd0);
    check($sformatf("level_after_frame dut%0d", id), {29'd0, lvl[id]}, 32'd0);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((sb.size() != 0 || busy != 4'b0) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check({name, " frames_outstanding"}, sb.size(), 32'd0);
    check({name, " busy_at_end"}, {28'd0, busy}, 32'd0);
  endtask

  task automatic monitor(input int id);
    exp_t f;
    logic eb [16];
    int   n, start_c, bad;
    int   end_c = -10;
    bit   aborted;
    n = 1 + DW_T[id] + ((PAR_T[id] != 0) ? 1 : 0) + STOP_T[id];
    forever begin
      @(negedge clk);
      if (!arstn || txw[id] !== 1'b0) continue;
      start_c = cyc;
      if (sb.size() == 0 || sb[0].id != id) begin
        tests++;
        fails++;
        $display("FAIL unexpected_frame dut%0d: start bit at cycle %0d, expected none", id, start_c);
        repeat (n * CPB) @(negedge clk);
        continue;
      end
      f = sb.pop_front();
      if (f.gap) check($sformatf("no_gap dut%0d %02h start_cycle", id, f.d), start_c, end_c + 1);
      eb[0] = 1'b0;
      for (int i = 0; i < DW_T[id]; i++) eb[1 + i] = f.d[i];
      if (PAR_T[id] != 0) eb[1 + DW_T[id]] = f.par;
      for (int i = n - STOP_T[id]; i < n; i++) eb[i] = 1'b1;
      aborted = 1'b0;
      for (int b = 0; b < n && !aborted; b++) begin
        bad = 0;
        for (int s = 0; s < CPB; s++) begin
          if (!(b == 0 && s == 0)) @(negedge clk);
          if (!arstn) begin aborted = 1'b1; break; end
          if (txw[id] !== eb[b]) bad++;
        end
        if (!aborted)
          check($sformatf("dut%0d byte %02h slot %0d wrong samples (want %0d)", id, f.d, b, eb[b]),
                bad, 32'd0);
      end
      end_c = cyc;
    end
  endtask

  initial fork
    monitor(0);
    monitor(1);
    monitor(2);
    monitor(3);
  join_none

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2, hi;
    for (int i = 0; i < 4; i++) td[i] = '0;

    // Reset values and release
    repeat (5) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset tx dut%0d", i), {31'd0, txw[i]}, 32'd1);
      check($sformatf("reset tready dut%0d", i), {31'd0, tready[i]}, 32'd0);
    end
    check("reset busy", {28'd0, busy}, 32'd0);
    check("reset level", {29'd0, lvl[0]}, 32'd0);
    @(posedge clk); #1 arstn = 1'b1;
    @(negedge clk);
    check("tready before first released edge", {31'd0, tready[0]}, 32'd0);
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      check($sformatf("tready after release dut%0d", i), {31'd0, tready[i]}, 32'd1);

    // Single frame 0x56
    @(posedge clk); #1;
    push(0, 8'h56, 1'b0, 1'b0, k);
    tvalid[0] = 1'b0;
    @(negedge clk);
    check("t1 tx idle on accept edge", {31'd0, txw[0]}, 32'd1);
    check("t1 level after accept", {29'd0, lvl[0]}, 32'd1);
    @(negedge clk);
    check("t1 tx start bit after k+1", {31'd0, txw[0]}, 32'd0);
    check("t1 level after pop", {29'd0, lvl[0]}, 32'd0);
    frame_end(0, k, 1000);
    drain("t1");

    // Back-to-back and full FIFO
    @(posedge clk); #1;
    push(0, 8'h55, 1'b0, 1'b0, k);
    push(0, 8'hA3, 1'b0, 1'b1, k2);
    push(0, 8'h0F, 1'b0, 1'b1, k2);
    push(0, 8'hF0, 1'b0, 1'b1, k2);
    push(0, 8'h81, 1'b0, 1'b1, k2);
    @(negedge clk);
    check("t2 level full", {29'd0, lvl[0]}, 32'd4);
    check("t2 tready when full", {31'd0, tready[0]}, 32'd0);
    push(0, 8'h7E, 1'b0, 1'b1, k2);
    check("t2 7E accepted when A3 popped", k2, k + 1002);
    tvalid[0] = 1'b0;
    drain("t2");

    // Simultaneous push and pop
    @(posedge clk); #1;
    push(0, 8'hC3, 1'b0, 1'b0, k);
    push(0, 8'h3C, 1'b0, 1'b1, k2);
    tvalid[0] = 1'b0;
    @(negedge clk);
    check("t6 second push on pop edge", k2, k + 1);
    check("t6 level unchanged by push+pop", {29'd0, lvl[0]}, 32'd1);
    drain("t6");

    // Parity: even then odd on 0x56
    @(posedge clk); #1;
    push(1, 8'h56, 1'b0, 1'b0, k);
    tvalid[1] = 1'b0;
    frame_end(1, k, 1100);
    drain("t3 even");
    @(posedge clk); #1;
    push(2, 8'h56, 1'b1, 1'b0, k);
    tvalid[2] = 1'b0;
    frame_end(2, k, 1100);
    drain("t3 odd");

    // 7 data bits, 2 stop bits, second frame right after 200 stop cycles
    @(posedge clk); #1;
    push(3, 8'h2B, 1'b0, 1'b0, k);
    push(3, 8'h55, 1'b0, 1'b1, k2);
    tvalid[3] = 1'b0;
    drain("t4");

    // Reset during data bit 3 with two words queued
    @(posedge clk); #1;
    push(0, 8'h11, 1'b0, 1'b0, k);
    push(0, 8'h22, 1'b0, 1'b0, k2);
    push(0, 8'h33, 1'b0, 1'b0, k2);
    tvalid[0] = 1'b0;
    @(negedge clk);
    check("t5 two words queued", {29'd0, lvl[0]}, 32'd2);
    while (cyc < k + 450) @(negedge clk);
    @(posedge clk); #1 arstn = 1'b0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    check("t5 tx high after reset edge", {31'd0, txw[0]}, 32'd1);
    check("t5 level flushed", {29'd0, lvl[0]}, 32'd0);
    check("t5 busy cleared", {31'd0, busy[0]}, 32'd0);
    check("t5 tready low in reset", {31'd0, tready[0]}, 32'd0);
    @(posedge clk); #1 arstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t5 tready after release", {31'd0, tready[0]}, 32'd1);
    hi = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (txw[0] !== 1'b1) hi++;
    end
    check("t5 no residual frame (low samples)", hi, 32'd0);
    check("t5 level still empty", {29'd0, lvl[0]}, 32'd0);
    @(posedge clk); #1;
    push(0, 8'hA5, 1'b0, 1'b0, k);
    tvalid[0] = 1'b0;
    drain("t5");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
